// File: rtl/pipeline_f_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_f_fetch
// Purpose  : Instruction fetch stage. Owns the PC, issues one read at a time,
//            and buffers {PC, IR} words in a 2-entry FIFO for the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_f_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        stall_in,
    output logic [15:0] IR_out,
    output logic [7:0]  PC_out,
    output logic        valid_out,
    output logic        halted_out
);

    logic [7:0]  r_fetch_pc;
    logic [7:0]  r_pc0;
    logic [7:0]  r_pc1;
    logic [15:0] r_ir0;
    logic [15:0] r_ir1;
    logic [1:0]  r_count;
    logic        r_outstanding;
    logic        r_discard;
    logic        r_halted;
    logic        r_mem_req;
    logic [7:0]  r_mem_addr;

    logic        w_pop;
    logic        w_push;
    logic        w_push_halt;
    logic        w_issue;
    logic        w_wr_hi;
    logic [1:0]  w_count_next;

    always_comb begin
        w_pop        = (r_count != 2'd0) && !stall_in;
        w_push       = mem_valid && r_outstanding && !r_discard;
        w_push_halt  = w_push && (mem_rdata[15:13] == 3'b111);
        w_count_next = r_count - {1'b0, w_pop} + {1'b0, w_push};
        // A new request needs a free slot after this cycle's pop/push.
        w_issue      = !redirect && !r_halted && !r_outstanding &&
                       (w_count_next < 2'd2) && !w_push_halt;
        // Entry 0 is always the head; a push lands behind whatever survives the pop.
        w_wr_hi      = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= 8'h00;
            r_pc0         <= 8'h00;
            r_pc1         <= 8'h00;
            r_ir0         <= 16'h0000;
            r_ir1         <= 16'h0000;
            r_count       <= 2'd0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_halted      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 8'h00;
        end else begin
            r_mem_req <= w_issue;
            if (w_issue) begin
                r_mem_addr <= r_fetch_pc;
            end
            if (redirect) begin
                r_count    <= 2'd0;
                r_fetch_pc <= redirect_pc;
                r_halted   <= 1'b0;
                if (mem_valid) begin
                    r_outstanding <= 1'b0;
                    r_discard     <= 1'b0;
                end else if (r_outstanding) begin
                    r_discard <= 1'b1;
                end
            end else begin
                r_count <= w_count_next;
                if (w_issue) begin
                    r_fetch_pc    <= r_fetch_pc + 8'd1;
                    r_outstanding <= 1'b1;
                end else if (mem_valid) begin
                    r_outstanding <= 1'b0;
                    r_discard     <= 1'b0;
                end
                if (w_push_halt) begin
                    r_halted <= 1'b1;
                end
                if (w_pop) begin
                    r_pc0 <= r_pc1;
                    r_ir0 <= r_ir1;
                end
                if (w_push) begin
                    if (w_wr_hi) begin
                        r_pc1 <= r_mem_addr;
                        r_ir1 <= mem_rdata;
                    end else begin
                        r_pc0 <= r_mem_addr;
                        r_ir0 <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign valid_out  = (r_count != 2'd0);
    assign IR_out     = valid_out ? r_ir0 : 16'h0000;
    assign PC_out     = valid_out ? r_pc0 : 8'h00;
    assign halted_out = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_f_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_f_fetch
// Purpose  : Self-checking bench for pipeline_f_fetch: directed scenarios plus
//            randomized stall/redirect/latency against an in-order stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_f_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        stall_in;
    logic [15:0] IR_out;
    logic [7:0]  PC_out;
    logic        valid_out;
    logic        halted_out;

    pipeline_f_fetch u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall_in   (stall_in),
        .IR_out     (IR_out),
        .PC_out     (PC_out),
        .valid_out  (valid_out),
        .halted_out (halted_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_dlv    = 0;
    logic [15:0] mem [256];
    int          lat      = 1;
    logic        resp_en  = 1'b1;
    int          pend_cnt = 0;
    logic [7:0]  pend_addr;
    logic [7:0]  last_pc  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory with a programmable latency (in cycles after the request edge).
    initial begin
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mem_valid = 1'b0;
                if (mem_req) begin
                    pend_addr = mem_addr;
                    pend_cnt  = lat;
                end
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = mem[pend_addr];
                    end
                end
            end
        end
    end

    // Reference model: requests go out at consecutive addresses from the last
    // reset/redirect, and decode sees exactly mem[pc], mem[pc+1], ... in order,
    // with nothing after a HALT word until the next redirect.
    logic [7:0] m_iss = 8'h00;
    logic [7:0] m_exp = 8'h00;
    logic       m_halt_dlv = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_iss      = 8'h00;
                m_exp      = 8'h00;
                m_halt_dlv = 1'b0;
            end else begin
                if (!valid_out) begin
                    check("idle_pc", PC_out, 8'h00);
                    check("idle_ir", IR_out, 16'h0000);
                end
                if (mem_req) begin
                    check("req_addr", mem_addr, m_iss);
                    check("req_while_halted", halted_out, 1'b0);
                    m_iss = m_iss + 8'd1;
                end
                if (m_halt_dlv) begin
                    check("halted_out", halted_out, 1'b1);
                end
                if (redirect) begin
                    m_iss      = redirect_pc;
                    m_exp      = redirect_pc;
                    m_halt_dlv = 1'b0;
                end else if (valid_out && !stall_in) begin
                    check("dlv_after_halt", m_halt_dlv, 1'b0);
                    check("dlv_pc", PC_out, m_exp);
                    check("dlv_ir", IR_out, mem[m_exp]);
                    n_dlv++;
                    last_pc = PC_out;
                    if (mem[m_exp][15:13] == 3'b111) m_halt_dlv = 1'b1;
                    m_exp = m_exp + 8'd1;
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; stall_in = 1'b0; redirect = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_ir", IR_out, 16'h0000);
        check("rst_pc", PC_out, 8'h00);
        check("rst_halted", halted_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (valid_out) break;
        end
        check(tag, valid_out, 1'b1);
    endtask

    int   nreq;
    int   d0;
    logic found;

    initial begin
        rst = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
        mem[0] = 16'hC105;
        mem[1] = 16'hC207;

        // Basic fetch timing with 1-cycle memory
        lat = 1;
        reset_dut();
        @(negedge clk); #1;
        check("t1_req0", mem_req, 1'b1);
        check("t1_addr0", mem_addr, 8'h00);
        check("t1_valid0", valid_out, 1'b0);
        @(negedge clk); #1;
        check("t1_valid1", valid_out, 1'b1);
        check("t1_pc0", PC_out, 8'h00);
        check("t1_ir0", IR_out, 16'hC105);
        check("t1_req_gap", mem_req, 1'b0);
        @(negedge clk); #1;
        check("t1_req1", mem_req, 1'b1);
        check("t1_addr1", mem_addr, 8'h01);
        @(negedge clk); #1;
        check("t1_pc1", PC_out, 8'h01);
        check("t1_ir1", IR_out, 16'hC207);
        repeat (6) @(negedge clk);

        // Stall holds the head and fills the FIFO
        reset_dut();
        stall_in = 1'b1;
        nreq = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (mem_req) nreq++;
        end
        check("t2_reqs", nreq, 2);
        check("t2_valid", valid_out, 1'b1);
        check("t2_pc", PC_out, 8'h00);
        check("t2_ir", IR_out, mem[0]);
        d0 = n_dlv;
        @(negedge clk);
        stall_in = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_drain", ((n_dlv - d0) >= 3), 1'b1);

        // Redirect while a slow request is in flight
        lat = 3;
        reset_dut();
        @(negedge clk); #1;
        check("t3_req", mem_req, 1'b1);
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t3_flushed", valid_out, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("t3_req40", mem_req, 1'b1);
        check("t3_addr40", mem_addr, 8'h40);
        repeat (3) @(negedge clk);
        #1;
        check("t3_valid", valid_out, 1'b1);
        check("t3_pc", PC_out, 8'h40);
        repeat (4) @(negedge clk);

        // HALT stops fetch until a redirect
        lat = 1;
        mem[5] = 16'hE000;
        reset_dut();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #1;
            found = halted_out;
        end
        check("t4_halted", halted_out, 1'b1);
        nreq = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (mem_req) nreq++;
        end
        check("t4_noreq", nreq, 0);
        check("t4_last_pc", last_pc, 8'h05);
        check("t4_empty", valid_out, 1'b0);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 8'h00;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t4_unhalt", halted_out, 1'b0);
        check("t4_flushed", valid_out, 1'b0);
        @(negedge clk); #1;
        check("t4_resume_req", mem_req, 1'b1);
        check("t4_resume_addr", mem_addr, 8'h00);

        // PC wrap from FF to 00
        reset_dut();
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 8'hFF;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("t5_valid_ff");
        check("t5_pc_ff", PC_out, 8'hFF);
        wait_valid("t5_valid_00");
        check("t5_pc_00", PC_out, 8'h00);

        // Reset with one entry buffered and a request in flight, late response after
        lat = 5;
        reset_dut();
        stall_in = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        check("t6_req1", mem_req, 1'b1);
        check("t6_addr1", mem_addr, 8'h01);
        @(negedge clk);
        resp_en = 1'b0; pend_cnt = 0; mem_valid = 1'b0;
        #1;
        check("t6_buffered", valid_out, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", valid_out, 1'b0);
        check("t6_rst_ir", IR_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0; stall_in = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'hE000;
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("t6_no_push", valid_out, 1'b0);
        check("t6_no_halt", halted_out, 1'b0);
        check("t6_pc", PC_out, 8'h00);
        check("t6_restart_req", mem_req, 1'b1);
        check("t6_restart_addr", mem_addr, 8'h00);

        // Randomized stall / redirect / latency with occasional HALT words
        @(negedge clk);
        resp_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 15) == 0) mem[i] = {3'b111, 13'($urandom)};
            else                            mem[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
        end
        lat = 1;
        reset_dut();
        d0 = n_dlv;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            stall_in    = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            lat         = $urandom_range(1, 4);
        end
        @(negedge clk);
        redirect = 1'b0; stall_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rand_progress", ((n_dlv - d0) > 30), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
